// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared state encoding, port IDs and word width for the data memory arbiter.
package data_mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_CPU = 3'd1,
        ACC_DBG = 3'd2,
        RSP_CPU = 3'd3,
        RSP_DBG = 3'd4
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// arb_starve_counter: saturating debug-port wait counter; at_max lets debug override CPU priority.
module arb_starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt;

    assign at_max = cnt == CW'(MAX_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_max)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: CPU/debug arbiter for the single-ported data memory, CPU priority with starvation bound.
// Optional ARB_PERF_EN adds saturating stall and conflict counters.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [WORD_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [WORD_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_stall,
    output logic [31:0]       perf_conflict
`endif
);

    arb_state_e state, state_d;
    logic arb, cpu_ok, dbg_ok, cpu_win, dbg_win, grant, sel, at_max;

    // A port sitting in its own RSP state still shows the old request, so it is not eligible.
    always_comb begin
        arb     = state == IDLE || state == RSP_CPU || state == RSP_DBG;
        cpu_ok  = cpu_req && state != RSP_CPU;
        dbg_ok  = dbg_req && state != RSP_DBG;
        dbg_win = arb && dbg_ok && (at_max || !cpu_ok);
        cpu_win = arb && cpu_ok && !dbg_win;
        grant   = cpu_win || dbg_win;
        sel     = dbg_win ? PORT_DBG : PORT_CPU;
        state_d = state == ACC_CPU ? RSP_CPU :
                  state == ACC_DBG ? RSP_DBG :
                  cpu_win          ? ACC_CPU :
                  dbg_win          ? ACC_DBG : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant) begin
            mem_en    <= 1'b1;
            mem_we    <= sel == PORT_DBG ? dbg_we : cpu_we;
            mem_addr  <= (sel == PORT_DBG ? dbg_addr : cpu_addr) & ~ADDR_W'(3);
            mem_wdata <= sel == PORT_DBG ? dbg_wdata : cpu_wdata;
        end else begin
            mem_en    <= 1'b0;
        end
    end

    arb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (dbg_win),
        .inc    (dbg_req && state != ACC_DBG && state != RSP_DBG),
        .at_max (at_max)
    );

    assign cpu_ack   = state == RSP_CPU;
    assign dbg_ack   = state == RSP_DBG;
    assign cpu_rdata = cpu_ack ? mem_rdata : '0;
    assign dbg_rdata = dbg_ack ? mem_rdata : '0;
    assign cpu_stall = cpu_req && !cpu_ack;

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall    <= '0;
            perf_conflict <= '0;
        end else begin
            if (cpu_stall && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
            if (arb && cpu_ok && dbg_ok && perf_conflict != '1)
                perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: table-driven and scoreboard bench for data_mem_arbiter with a synchronous memory model.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int MW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
    logic cpu_ack, cpu_stall, dbg_ack, mem_en, mem_we;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef ARB_PERF_EN
    logic [31:0] perf_stall, perf_conflict;
`endif

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        , .perf_stall(perf_stall), .perf_conflict(perf_conflict)
`endif
    );

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];

    always @(posedge clk)
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else mem_rdata <= mem[mem_addr[9:2]];
        end

    typedef struct {
        logic chk;
        logic [31:0] d;
    } exp_t;
    exp_t cpu_q[$];
    exp_t dbg_q[$];

    typedef struct {
        bit p;
        bit we;
        logic [31:0] addr, wdata, exp_rd, exp_ma;
    } vec_t;
    vec_t vecs [8];

    int tests = 0;
    int fails = 0;
    int m_stall = 0;
    logic stall_at_dack = 1'b0;

    always @(negedge clk) begin
        if (cpu_stall) m_stall++;
        if (dbg_ack) stall_at_dack = cpu_stall;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one access on port p, waits for its ack, and checks the ACC-cycle command and the read data.
    task automatic txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int stl, output logic [31:0] ma, output logic [31:0] rd);
        exp_t e, got;
        logic [31:0] al;
        logic pm_en, pm_we, ack;
        logic [31:0] pm_wdata;
        bit done;
        al = addr & 32'hFFFF_FFFC;
        e.chk = !we;
        e.d = ref_mem[al[9:2]];
        if (we) ref_mem[al[9:2]] = wdata;
        if (p) dbg_q.push_back(e); else cpu_q.push_back(e);
        if (p) begin dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1; end
        else begin cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1; end
        lat = 0; stl = 0; done = 0; ma = '0; rd = '0; pm_en = 0; pm_we = 0; pm_wdata = '0;
        while (!done && lat < 20) begin
            @(negedge clk);
            ack = p ? dbg_ack : cpu_ack;
            if (ack) begin
                done = 1;
                rd = p ? dbg_rdata : cpu_rdata;
            end else begin
                lat++;
                if (p || cpu_stall) stl++;
                pm_en = mem_en; pm_we = mem_we; ma = mem_addr; pm_wdata = mem_wdata;
            end
        end
        if (!done) begin
            check(p ? "dbg_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
        end else begin
            got = p ? dbg_q.pop_front() : cpu_q.pop_front();
            if (got.chk) check(p ? "dbg_rdata_sb" : "cpu_rdata_sb", rd, got.d);
            if (!p) check("cpu_stall_at_ack", 32'(cpu_stall), 32'd0);
            check("acc_mem_en", 32'(pm_en), 32'd1);
            check("acc_mem_we", 32'(pm_we), 32'(we));
            check("acc_mem_addr", ma, al);
            if (we) check("acc_mem_wdata", pm_wdata, wdata);
        end
        @(posedge clk);
        #1;
        check(p ? "dbg_ack_pulse" : "cpu_ack_pulse", 32'(p ? dbg_ack : cpu_ack), 32'd0);
        if (p) dbg_req = 1'b0; else cpu_req = 1'b0;
    endtask

    initial begin
        int lat, stl, dlat, dstl;
        int s0, c0;
        bit saw_ack;
        logic [31:0] ma, rd;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        vecs[0] = '{0, 1, 32'd12,   32'd45,         32'd0,          32'd12};
        vecs[1] = '{0, 0, 32'd12,   32'd0,          32'd45,         32'd12};
        vecs[2] = '{0, 1, 32'h0E,   32'h11,         32'd0,          32'h0C};
        vecs[3] = '{0, 0, 32'h0C,   32'd0,          32'h11,         32'h0C};
        vecs[4] = '{1, 1, 32'h40,   32'hCAFEF00D,   32'd0,          32'h40};
        vecs[5] = '{1, 0, 32'h40,   32'd0,          32'hCAFEF00D,   32'h40};
        vecs[6] = '{0, 0, 32'h43,   32'd0,          32'hCAFEF00D,   32'h40};
        vecs[7] = '{1, 0, 32'h0E,   32'd0,          32'h11,         32'h0C};

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, stl, ma, rd);
            check("vec_latency", 32'(lat), 32'd2);
            check("vec_mem_addr", ma, vecs[i].exp_ma);
            if (!vecs[i].we) check("vec_rdata", rd, vecs[i].exp_rd);
            if (!vecs[i].p) check("vec_cpu_stall_cycles", 32'(stl), 32'd2);
        end

        // Simultaneous requests from IDLE: CPU first, debug command in the cycle after CPU ack.
        fork
            txn(0, 0, 32'd0, 32'd0, lat, stl, ma, rd);
            txn(1, 1, 32'd8, 32'hDEADBEEF, dlat, dstl, ma, rd);
        join
        check("both_cpu_latency", 32'(lat), 32'd2);
        check("both_dbg_latency", 32'(dlat), 32'd4);
        txn(0, 0, 32'd8, 32'd0, lat, stl, ma, rd);
        check("readback_deadbeef", rd, 32'hDEADBEEF);

        // Continuous CPU traffic: debug must still be granted within the starvation bound.
        fork
            for (int i = 0; i < 6; i++) txn(0, 0, 32'(i * 4), 32'd0, lat, stl, ma, rd);
            begin
                repeat (2) @(posedge clk);
                #1;
                txn(1, 0, 32'h40, 32'd0, dlat, dstl, ma, rd);
            end
        join
        check("starve_bound", 32'(dlat <= MW + 3), 32'd1);
        check("cpu_stall_during_dbg", 32'(stall_at_dack), 32'd1);

        // Reset during the debug write's access cycle discards it.
        dbg_we = 1'b1; dbg_addr = 32'h80; dbg_wdata = 32'h12345678; dbg_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_mem_en", 32'(mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        check("midrst_mem_addr", mem_addr, 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        dbg_req = 1'b0;
        saw_ack = 0;
        repeat (2) begin @(negedge clk); if (dbg_ack) saw_ack = 1; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (dbg_ack) saw_ack = 1; end
        check("midrst_no_dbg_ack", 32'(saw_ack), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        check("midrst_dbg_rdata", dbg_rdata, 32'd0);
        @(posedge clk);
        #1;
        txn(0, 0, 32'h80, 32'd0, lat, stl, ma, rd);
        check("discarded_write", rd, 32'd0);

`ifdef ARB_PERF_EN
        s0 = m_stall;
        c0 = 0;
        check("perf_stall_sync", perf_stall, 32'(s0));
        c0 = int'(perf_conflict);
        for (int i = 0; i < 10; i++)
            fork
                txn(0, 0, 32'(i * 4), 32'd0, lat, stl, ma, rd);
                txn(1, 1, 32'h100 + 32'(i * 4), 32'(i), dlat, dstl, ma, rd);
            join
        check("perf_conflict", perf_conflict - 32'(c0), 32'd10);
        check("perf_stall_delta", perf_stall - 32'(s0), 32'(m_stall - s0));
        check("perf_stall_20", 32'(m_stall - s0), 32'd20);
`else
        s0 = 0;
        c0 = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
